// File: rtl/i2s_rx_48k_if.sv
// i2s_rx_48k_if: I2S receive link plus the frame-aligned stereo sample bus.
//   i2s_bclk, i2s_lrclk, i2s_sdata  : raw I2S lines (async to the system clock)
//   clken48kHz                      : one-cycle output-update enable
//   clr_flags                       : synchronous clear of the sticky flags
//   LEFTout, RIGHTout               : OUT_W-bit signed sample pair
//   frame_valid, stale              : one-cycle status pulses per clken48kHz
//   overrun, sync_err               : sticky error flags
// master = source side (I2S transmitter + consumer), slave = the receiver.
interface i2s_rx_48k_if #(
  parameter int unsigned OUT_W = 18
);

  logic                    i2s_bclk;
  logic                    i2s_lrclk;
  logic                    i2s_sdata;
  logic                    clken48kHz;
  logic                    clr_flags;
  logic signed [OUT_W-1:0] LEFTout;
  logic signed [OUT_W-1:0] RIGHTout;
  logic                    frame_valid;
  logic                    stale;
  logic                    overrun;
  logic                    sync_err;

  modport master (
    output i2s_bclk, i2s_lrclk, i2s_sdata, clken48kHz, clr_flags,
    input  LEFTout, RIGHTout, frame_valid, stale, overrun, sync_err
  );

  modport slave (
    input  i2s_bclk, i2s_lrclk, i2s_sdata, clken48kHz, clr_flags,
    output LEFTout, RIGHTout, frame_valid, stale, overrun, sync_err
  );

endinterface

// File: rtl/i2s_rx_48k.sv
// i2s_rx_48k: oversampling I2S receiver for a 48 kHz stereo stream.
// Deserialises MSB-first DATA_W-bit words, truncates them to OUT_W bits and
// presents a frame-aligned LEFT/RIGHT pair that only changes on clken48kHz.
//   clock : system clock (>= 8x bclk)
//   reset : asynchronous, active-low reset
//   bus   : i2s_rx_48k_if.slave (I2S lines in, sample pair and status out)
// OUT_W must not exceed DATA_W; SYNC_STAGES must be at least 2.
module i2s_rx_48k #(
  parameter int unsigned DATA_W      = 24,
  parameter int unsigned OUT_W       = 18,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clock,
  input  logic         reset,
  i2s_rx_48k_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SKIP,
    ST_SHIFT,
    ST_PAD
  } state_t;

  // Synchroniser chains and bclk edge detect
  logic [SYNC_STAGES-1:0] r_bclk_sync;
  logic [SYNC_STAGES-1:0] r_lr_sync;
  logic [SYNC_STAGES-1:0] r_sd_sync;
  logic                   r_bclk_d;
  logic                   w_bclk_rise;

  // Per-bclk-edge samples
  logic r_evt;
  logic r_lr_smp;
  logic r_sd_smp;
  logic r_lr_prev;
  logic w_lr_edge;
  logic w_left_start;

  // Deserialiser
  state_t              r_state;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [DATA_W-2:0]   r_shreg;
  logic [DATA_W-1:0]   w_word;
  logic                w_last_bit;
  logic                w_word_done;
  logic                w_pair_done;
  logic                w_sync_err_set;
  logic                r_chan;
  logic                r_left_got;
  logic [OUT_W-1:0]    r_left_stage;
  logic [OUT_W-1:0]    r_left_hold;
  logic [OUT_W-1:0]    r_right_hold;

  // Output side
  logic                r_pair_ready;
  logic [OUT_W-1:0]    r_left_out;
  logic [OUT_W-1:0]    r_right_out;
  logic                r_frame_valid;
  logic                r_stale;
  logic                r_overrun;
  logic                r_sync_err;

  // Bring the three I2S lines into the clock domain with equal latency.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_bclk_sync <= '0;
      r_lr_sync   <= '0;
      r_sd_sync   <= '0;
      r_bclk_d    <= 1'b0;
    end else begin
      r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], bus.i2s_bclk};
      r_lr_sync   <= {r_lr_sync[SYNC_STAGES-2:0],   bus.i2s_lrclk};
      r_sd_sync   <= {r_sd_sync[SYNC_STAGES-2:0],   bus.i2s_sdata};
      r_bclk_d    <= r_bclk_sync[SYNC_STAGES-1];
    end
  end

  assign w_bclk_rise = r_bclk_sync[SYNC_STAGES-1] & ~r_bclk_d;

  // Capture lrclk/sdata once per bclk rising edge; r_evt marks the new sample.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_evt     <= 1'b0;
      r_lr_smp  <= 1'b0;
      r_sd_smp  <= 1'b0;
      r_lr_prev <= 1'b0;
    end else begin
      r_evt <= w_bclk_rise;
      if (w_bclk_rise) begin
        r_lr_smp  <= r_lr_sync[SYNC_STAGES-1];
        r_sd_smp  <= r_sd_sync[SYNC_STAGES-1];
        r_lr_prev <= r_lr_smp;
      end
    end
  end

  assign w_lr_edge    = r_evt && (r_lr_smp != r_lr_prev);
  assign w_left_start = w_lr_edge && !r_lr_smp;

  assign w_word         = {r_shreg, r_sd_smp};
  assign w_last_bit     = (r_bit_cnt == CNT_W'(DATA_W - 1));
  assign w_word_done    = (r_state == ST_SHIFT) && r_evt && !w_lr_edge && w_last_bit;
  assign w_pair_done    = w_word_done && r_chan && r_left_got;
  assign w_sync_err_set = (r_state == ST_SHIFT) && w_lr_edge;

  // Word framing FSM. The bclk edge that reveals an lrclk change carries the
  // previous word's last slot (the I2S one-bit delay), so SKIP only arms the
  // counter and the next edge delivers the MSB. A left word is staged until
  // its right partner arrives, so the hold pair is always from one frame.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_shreg      <= '0;
      r_chan       <= 1'b0;
      r_left_got   <= 1'b0;
      r_left_stage <= '0;
      r_left_hold  <= '0;
      r_right_hold <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_left_start) begin
            r_state <= ST_SKIP;
          end
        end
        ST_SKIP: begin
          r_chan    <= r_lr_smp;
          r_bit_cnt <= '0;
          r_state   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (r_evt) begin
            if (w_lr_edge) begin
              r_left_got <= 1'b0;
              r_state    <= ST_IDLE;
            end else begin
              r_shreg   <= w_word[DATA_W-2:0];
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
              if (w_last_bit) begin
                r_state <= ST_PAD;
                if (r_chan) begin
                  if (r_left_got) begin
                    r_left_hold  <= r_left_stage;
                    r_right_hold <= w_word[DATA_W-1 -: OUT_W];
                  end
                  r_left_got <= 1'b0;
                end else begin
                  r_left_stage <= w_word[DATA_W-1 -: OUT_W];
                  r_left_got   <= 1'b1;
                end
              end
            end
          end
        end
        ST_PAD: begin
          if (w_lr_edge) begin
            r_state <= ST_SKIP;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Output update on clken48kHz. The pair_ready seen here is the value before
  // any same-cycle completion, so a coincident pair stays pending.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pair_ready  <= 1'b0;
      r_left_out    <= '0;
      r_right_out   <= '0;
      r_frame_valid <= 1'b0;
      r_stale       <= 1'b0;
      r_overrun     <= 1'b0;
      r_sync_err    <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      r_stale       <= 1'b0;

      if (bus.clken48kHz) begin
        if (r_pair_ready) begin
          r_left_out    <= r_left_hold;
          r_right_out   <= r_right_hold;
          r_frame_valid <= 1'b1;
        end else begin
          r_stale <= 1'b1;
        end
      end

      if (w_pair_done) begin
        r_pair_ready <= 1'b1;
      end else if (bus.clken48kHz) begin
        r_pair_ready <= 1'b0;
      end

      // Set wins over clear; a pair consumed in the completion cycle is not lost.
      if (w_pair_done && r_pair_ready && !bus.clken48kHz) begin
        r_overrun <= 1'b1;
      end else if (bus.clr_flags) begin
        r_overrun <= 1'b0;
      end

      if (w_sync_err_set) begin
        r_sync_err <= 1'b1;
      end else if (bus.clr_flags) begin
        r_sync_err <= 1'b0;
      end
    end
  end

  assign bus.LEFTout     = r_left_out;
  assign bus.RIGHTout    = r_right_out;
  assign bus.frame_valid = r_frame_valid;
  assign bus.stale       = r_stale;
  assign bus.overrun     = r_overrun;
  assign bus.sync_err    = r_sync_err;

endmodule

// File: tb/tb_i2s_rx_48k.sv
// tb_i2s_rx_48k: self-checking bench for i2s_rx_48k. Drives 64-slot I2S frames
// (32 bclk per channel, one-bit delay) and compares against a pair-level model.
module tb_i2s_rx_48k;

  localparam int unsigned DW = 24;
  localparam int unsigned OW = 18;
  localparam int unsigned SS = 2;
  localparam int          HALF_BCLK = 50;   // bclk = clock / 10

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  int   rise_cnt;

  // Reference model: one pending pair, the presented pair and the flags.
  bit            m_pend;
  logic [OW-1:0] m_pl, m_pr, m_ol, m_or;
  bit            m_ovr, m_serr, m_fv, m_st;

  i2s_rx_48k_if #(.OUT_W(OW)) bus ();

  i2s_rx_48k #(
    .DATA_W      (DW),
    .OUT_W       (OW),
    .SYNC_STAGES (SS)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  function automatic logic [OW-1:0] trunc(input logic [DW-1:0] w);
    return OW'(w >> (DW - OW));
  endfunction

  function automatic logic [43:0] dut_vec();
    return {bus.frame_valid, bus.stale, bus.overrun, bus.sync_err,
            2'b00, bus.LEFTout, 2'b00, bus.RIGHTout};
  endfunction

  function automatic logic [43:0] model_vec();
    return {m_fv, m_st, m_ovr, m_serr, 2'b00, m_ol, 2'b00, m_or};
  endfunction

  task automatic model_reset();
    m_pend = 0; m_pl = '0; m_pr = '0; m_ol = '0; m_or = '0;
    m_ovr = 0; m_serr = 0; m_fv = 0; m_st = 0;
  endtask

  task automatic model_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
    if (m_pend) m_ovr = 1;
    m_pend = 1;
    m_pl = trunc(l);
    m_pr = trunc(r);
    m_fv = 0;
    m_st = 0;
  endtask

  task automatic model_clken();
    m_fv = 0;
    m_st = 0;
    if (m_pend) begin
      m_ol = m_pl; m_or = m_pr; m_pend = 0; m_fv = 1;
    end else begin
      m_st = 1;
    end
  endtask

  // One bclk period: data changes on the falling edge, sampled on the rising.
  task automatic slot(input logic lr, input logic b);
    bus.i2s_bclk  = 1'b0;
    bus.i2s_lrclk = lr;
    bus.i2s_sdata = b;
    #HALF_BCLK;
    bus.i2s_bclk = 1'b1;
    rise_cnt++;
    #HALF_BCLK;
  endtask

  // Puts bclk rising edges 2 time units after a clock rising edge.
  task automatic align();
    @(posedge clk);
    #2;
  endtask

  task automatic send_word(input logic lr, input logic [DW-1:0] w, input int nbits);
    slot(lr, 1'($urandom));
    for (int i = 0; i < nbits; i++) slot(lr, w[DW-1-i]);
    if (nbits == DW) for (int i = DW + 1; i < 32; i++) slot(lr, 1'($urandom));
  endtask

  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
    align();
    send_word(1'b0, l, DW);
    send_word(1'b1, r, DW);
  endtask

  task automatic idle_slots(input int n);
    align();
    repeat (n) slot(1'b1, 1'($urandom));
  endtask

  task automatic pulse_clken();
    @(negedge clk) bus.clken48kHz = 1'b1;
    @(negedge clk) bus.clken48kHz = 1'b0;
    model_clken();
  endtask

  task automatic pulse_clr();
    @(negedge clk) bus.clr_flags = 1'b1;
    @(negedge clk) bus.clr_flags = 1'b0;
    m_ovr = 0; m_serr = 0; m_fv = 0; m_st = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk) bus.clken48kHz = 1'b1;
      @(negedge clk) bus.clken48kHz = 1'b0;
      n_vec++;
      if (dut_vec() !== model_vec()) begin
        n_err++; $display("FAIL reset_hold[%0d] got %h exp %h", i, dut_vec(), model_vec());
      end
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      pulse_clken();
      n_vec++;
      if (dut_vec() !== model_vec()) begin
        n_err++; $display("FAIL idle_stale[%0d] got %h exp %h", i, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_basic();
    idle_slots(4);
    send_frame(24'h7FFFC0, 24'h800000);
    model_pair(24'h7FFFC0, 24'h800000);
    repeat (4) @(negedge clk);
    n_vec++;
    if (dut_vec() !== model_vec()) begin
      n_err++; $display("FAIL basic_pending got %h exp %h", dut_vec(), model_vec());
    end
    pulse_clken();
    n_vec++;
    if (dut_vec() !== model_vec()) begin
      n_err++; $display("FAIL basic_frame got %h exp %h", dut_vec(), model_vec());
    end
    n_vec++;
    if (bus.LEFTout !== 18'h1FFFF || bus.RIGHTout !== 18'h20000 || bus.frame_valid !== 1'b1) begin
      n_err++; $display("FAIL basic_const got L=%h R=%h fv=%b exp L=1ffff R=20000 fv=1",
                        bus.LEFTout, bus.RIGHTout, bus.frame_valid);
    end
  endtask

  task automatic test_sign_trunc();
    send_frame(24'hFFFFFF, 24'h00003F);
    model_pair(24'hFFFFFF, 24'h00003F);
    pulse_clken();
    n_vec++;
    if (dut_vec() !== model_vec()) begin
      n_err++; $display("FAIL sign_trunc got %h exp %h", dut_vec(), model_vec());
    end
    n_vec++;
    if (bus.LEFTout !== 18'h3FFFF || bus.RIGHTout !== 18'h00000) begin
      n_err++; $display("FAIL sign_const got L=%h R=%h exp L=3ffff R=00000", bus.LEFTout, bus.RIGHTout);
    end
  endtask

  task automatic test_overrun();
    send_frame(24'h123456, 24'h654321);
    model_pair(24'h123456, 24'h654321);
    send_frame(24'h111111, 24'h222222);
    model_pair(24'h111111, 24'h222222);
    repeat (4) @(negedge clk);
    n_vec++;
    if (dut_vec() !== model_vec()) begin
      n_err++; $display("FAIL overrun_flag got %h exp %h", dut_vec(), model_vec());
    end
    pulse_clken();
    n_vec++;
    if (dut_vec() !== model_vec()) begin
      n_err++; $display("FAIL overrun_pair got %h exp %h", dut_vec(), model_vec());
    end
    n_vec++;
    if (bus.LEFTout !== 18'h04444 || bus.RIGHTout !== 18'h08888 || bus.overrun !== 1'b1) begin
      n_err++; $display("FAIL overrun_const got L=%h R=%h ov=%b exp L=04444 R=08888 ov=1",
                        bus.LEFTout, bus.RIGHTout, bus.overrun);
    end
    pulse_clr();
    n_vec++;
    if (dut_vec() !== model_vec()) begin
      n_err++; $display("FAIL overrun_clear got %h exp %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_short_word();
    align();
    send_word(1'b0, 24'($urandom), 10);
    send_word(1'b1, 24'($urandom), DW);
    m_serr = 1; m_fv = 0; m_st = 0;
    repeat (4) @(negedge clk);
    n_vec++;
    if (dut_vec() !== model_vec()) begin
      n_err++; $display("FAIL short_syncerr got %h exp %h", dut_vec(), model_vec());
    end
    pulse_clken();
    n_vec++;
    if (dut_vec() !== model_vec()) begin
      n_err++; $display("FAIL short_stale got %h exp %h", dut_vec(), model_vec());
    end
    send_frame(24'h400000, 24'hC00000);
    model_pair(24'h400000, 24'hC00000);
    pulse_clken();
    n_vec++;
    if (dut_vec() !== model_vec() || bus.LEFTout !== 18'h10000 || bus.RIGHTout !== 18'h30000) begin
      n_err++; $display("FAIL short_recover got %h exp %h", dut_vec(), model_vec());
    end
    pulse_clr();
    n_vec++;
    if (dut_vec() !== model_vec()) begin
      n_err++; $display("FAIL short_clear got %h exp %h", dut_vec(), model_vec());
    end
  endtask

  // clken48kHz lands on the clock that registers the right word's last bit:
  // that bit is seen SS+1 clocks after its bclk edge and stored one clock later.
  task automatic test_coincidence();
    logic [DW-1:0] l, r;
    int base;
    l = 24'($urandom);
    r = 24'($urandom);
    fork
      send_frame(l, r);
      begin
        base = rise_cnt;
        wait (rise_cnt == base + 32 + 1 + int'(DW));
        repeat (SS + 1) @(posedge clk);
        #1 bus.clken48kHz = 1'b1;
        @(posedge clk);
        #1 bus.clken48kHz = 1'b0;
        model_clken();
        #3;
        n_vec++;
        if (dut_vec() !== model_vec()) begin
          n_err++; $display("FAIL coincide_stale got %h exp %h", dut_vec(), model_vec());
        end
        model_pair(l, r);
      end
    join
    pulse_clken();
    n_vec++;
    if (dut_vec() !== model_vec()) begin
      n_err++; $display("FAIL coincide_next got %h exp %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] l, r;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < int'($urandom_range(1, 2)); j++) begin
        l = 24'($urandom);
        r = 24'($urandom);
        send_frame(l, r);
        model_pair(l, r);
      end
      pulse_clken();
      n_vec++;
      if (dut_vec() !== model_vec()) begin
        n_err++; $display("FAIL random[%0d] got %h exp %h", k, dut_vec(), model_vec());
      end
      if ($urandom_range(0, 2) == 0) begin
        pulse_clken();
        n_vec++;
        if (dut_vec() !== model_vec()) begin
          n_err++; $display("FAIL random_stale[%0d] got %h exp %h", k, dut_vec(), model_vec());
        end
      end
      if ($urandom_range(0, 1) == 0) begin
        pulse_clr();
        n_vec++;
        if (dut_vec() !== model_vec()) begin
          n_err++; $display("FAIL random_clr[%0d] got %h exp %h", k, dut_vec(), model_vec());
        end
      end
    end
  endtask

  task automatic test_reset_midword();
    logic [DW-1:0] l, r;
    l = 24'($urandom);
    r = 24'($urandom);
    fork
      send_frame(l, r);
      begin
        #(20 * HALF_BCLK);
        rst_n = 1'b0;
        model_reset();
        #30;
        rst_n = 1'b1;
      end
    join
    n_vec++;
    if (dut_vec() !== model_vec()) begin
      n_err++; $display("FAIL midword_reset got %h exp %h", dut_vec(), model_vec());
    end
    pulse_clken();
    n_vec++;
    if (dut_vec() !== model_vec()) begin
      n_err++; $display("FAIL midword_stale got %h exp %h", dut_vec(), model_vec());
    end
    l = 24'($urandom);
    r = 24'($urandom);
    send_frame(l, r);
    model_pair(l, r);
    pulse_clken();
    n_vec++;
    if (dut_vec() !== model_vec()) begin
      n_err++; $display("FAIL midword_realign got %h exp %h", dut_vec(), model_vec());
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rise_cnt = 0;
    rst_n = 1'b0;
    bus.i2s_bclk   = 1'b0;
    bus.i2s_lrclk  = 1'b1;
    bus.i2s_sdata  = 1'b0;
    bus.clken48kHz = 1'b0;
    bus.clr_flags  = 1'b0;
    model_reset();

    test_reset();
    test_basic();
    test_sign_trunc();
    test_overrun();
    test_short_word();
    test_coincidence();
    test_random();
    test_reset_midword();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/i2s_rx_48k.md
Name: i2s_rx_48k

Overview:
- Audio front-end upstream of the stereo FM modulator top level. Receives a 48 kHz stereo I2S stream with the single system clock by oversampling bclk, lrclk and sdata. Deserialises each word and truncates it to 18-bit signed.
- Presents the LEFT/RIGHT pair, updated only on clken48kHz, so the downstream sum/difference stage always sees a stable, frame-aligned pair for a full 48 kHz period.

Parameters:
DATA_W, 24, I2S word length in bits (MSB first), 18..32
OUT_W, 18, output sample width; OUT_W <= DATA_W
SYNC_STAGES, 2, synchroniser depth for the three I2S inputs, >= 2

Ports:
clock  in  1  system clock; must be >= 8x bclk frequency
reset  in  1  asynchronous, active-low reset
i2s_bclk  in  1  I2S bit clock, asynchronous to clock
i2s_lrclk  in  1  word select: 0 = left, 1 = right
i2s_sdata  in  1  serial data, valid at bclk rising edge
clken48kHz  in  1  one-cycle output-update enable
clr_flags  in  1  synchronous clear of sticky flags
LEFTout  out  OUT_W signed  left sample, feeds LEFTin of modulator
RIGHTout  out  OUT_W signed  right sample, feeds RIGHTin of modulator
frame_valid  out  1  one-cycle pulse: new pair loaded on this clken48kHz
stale  out  1  one-cycle pulse: clken48kHz with no new pair, outputs held
overrun  out  1  sticky: a completed pair was overwritten before being consumed
sync_err  out  1  sticky: lrclk changed before DATA_W bits were received

Behaviour:
- Reset (reset=0, async): all outputs 0, FSM to IDLE, holding registers 0, pair_ready 0.
- Inputs pass through SYNC_STAGES flops. A bclk rising edge is detected by comparing the synchronised bclk with its delayed copy. lrclk and sdata are sampled only on a detected edge. External edge to internal event is SYNC_STAGES+1 clocks.
- lrclk edge means the sampled lrclk differs from the previous sampled lrclk.
- FSM states:
  - IDLE: wait for lrclk 1->0 (left start); then SKIP. Right words before the first left are ignored.
  - SKIP: the I2S one-bit delay. Consume 1 bclk edge, clear bit_cnt, go to SHIFT.
  - SHIFT: shift sdata into shreg MSB-first and increment bit_cnt. When bit_cnt reaches DATA_W, store to left_hold or right_hold according to the current channel and go to PAD. If an lrclk edge occurs first, discard the word, set sync_err and go to IDLE.
  - PAD: ignore bits until an lrclk edge, then SKIP with the channel taken from the new lrclk.
- Pair completion: when the right word is stored and a left word was stored in the same frame, set pair_ready. If pair_ready is already 1 at that point, set overrun; the new pair overwrites the old one.
- Truncation: LEFTout/RIGHTout = hold[DATA_W-1 : DATA_W-OUT_W]. Truncate only, no rounding; the sign is preserved.
- On clken48kHz:
  - If pair_ready=1: load outputs from the holds, clear pair_ready, pulse frame_valid.
  - Otherwise: hold outputs and pulse stale.
- clken48kHz in the same cycle as a pair completion: use the pair_ready value from before the update (load the previous pair, or stale). The new pair becomes pending with pair_ready=1, and overrun is not set.
- Outputs change only on clken48kHz cycles (registered, latency 1 clock from clken48kHz).
- clr_flags clears overrun and sync_err. A set event in the same cycle wins.
- Reset mid-word discards partial data. The first frame after reset is aligned from IDLE.

Test Plan:
- Reset and idle: hold reset=0, toggle clken48kHz -> all outputs 0. After release with no I2S activity, each clken48kHz gives stale=1, frame_valid=0, outputs remain 0.
- Basic frame: clock 100 MHz, bclk 3.072 MHz (64 bclk/frame), send L=0x7FFFC0 and R=0x800000. At the next clken48kHz -> frame_valid=1, LEFTout=0x1FFFF, RIGHTout=0x20000 (-131072).
- Sign and truncation: L=0xFFFFFF, R=0x00003F -> LEFTout=0x3FFFF (-1), RIGHTout=0x00000.
- Overrun: send two frames (L=0x123456/R=0x654321, then L=0x111111/R=0x222222) with no clken48kHz between them -> overrun=1. Next clken48kHz gives LEFTout=0x111111>>6=0x04444, RIGHTout=0x08888. clr_flags -> overrun=0.
- Short word: toggle lrclk after 10 bits of a left word -> sync_err=1, no frame_valid at the next clken48kHz (stale=1). The following full frame L=0x400000/R=0xC00000 yields 0x10000/0x30000.
- Coincidence: assert clken48kHz in the exact cycle the right word completes -> stale=1 with outputs unchanged. The next clken48kHz gives frame_valid=1 with the new pair and overrun=0.
